// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX->MEM pipeline register with a two-entry skid buffer.
// Main entry M drives the out_* ports. Skid entry S catches a beat accepted
// while M is stalled, so in_ready can come straight from a flop.
// Optional macro EX_MEM_OF_TRAP_EN: a signed overflow on add/sub is marked as
// an exception and its register/memory writes are squashed.
module ex_mem_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_aluout,
  input  logic                      in_zero,
  input  logic                      in_of,
  input  logic                      in_uof,
  input  logic [3:0]                in_aluop,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic                      in_regwrite,
  input  logic                      in_memread,
  input  logic                      in_memwrite,
  input  logic [DATA_WIDTH-1:0]     in_store_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_aluout,
  output logic                      out_zero,
  output logic                      out_uof,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic                      out_regwrite,
  output logic                      out_memread,
  output logic                      out_memwrite,
  output logic [DATA_WIDTH-1:0]     out_store_data,
  output logic                      out_exc,
  output logic                      exc_sticky
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     aluout;
    logic                      zero;
    logic                      uof;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      regwrite;
    logic                      memread;
    logic                      memwrite;
    logic [DATA_WIDTH-1:0]     store_data;
  } beat_t;

  beat_t in_beat, m_q, s_q;
  logic  m_vld, s_vld, rdy_q;
  logic  m_vld_d, s_vld_d, m_load, m_from_s, s_load;
  logic  accept, xfer, in_exc;

  assign accept = in_valid && rdy_q;
  assign xfer   = m_vld && out_ready;

  // Incoming beat, with control bits squashed when it traps
  always_comb begin
    in_beat            = '0;
    in_beat.aluout     = in_aluout;
    in_beat.zero       = in_zero;
    in_beat.uof        = in_uof;
    in_beat.rd         = in_rd;
    in_beat.store_data = in_store_data;
`ifdef EX_MEM_OF_TRAP_EN
    in_exc = in_of && (in_aluop == 4'd5 || in_aluop == 4'd6);
`else
    in_exc = 1'b0;
`endif
    in_beat.regwrite = in_regwrite && !in_exc;
    in_beat.memread  = in_memread  && !in_exc;
    in_beat.memwrite = in_memwrite && !in_exc;
  end

`ifndef EX_MEM_OF_TRAP_EN
  // of/aluop only matter to the trap logic
  logic unused_trap_in;
  assign unused_trap_in = ^{in_of, in_aluop};
`endif

  // Next-state of the two entries; at most one of m_load/m_from_s/s_load fires
  always_comb begin
    m_vld_d  = m_vld;
    s_vld_d  = s_vld;
    m_load   = 1'b0;
    m_from_s = 1'b0;
    s_load   = 1'b0;
    if (!m_vld) begin
      if (accept) begin
        m_load  = 1'b1;
        m_vld_d = 1'b1;
      end
    end else if (xfer) begin
      if (accept) begin
        m_load = 1'b1;           // S is empty whenever accept is possible
      end else if (s_vld) begin
        m_from_s = 1'b1;
        s_vld_d  = 1'b0;
      end else begin
        m_vld_d = 1'b0;
      end
    end else if (accept) begin
      s_load  = 1'b1;
      s_vld_d = 1'b1;
    end
  end

  // Valid bits and registered in_ready; flush beats everything except reset
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      m_vld <= m_vld_d;
      s_vld <= s_vld_d;
      rdy_q <= !s_vld_d;
    end
  end

  // Payload registers load only on accept or S->M move
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_q <= '0;
      s_q <= '0;
    end else if (!flush) begin
      if (m_load)        m_q <= in_beat;
      else if (m_from_s) m_q <= s_q;
      if (s_load)        s_q <= in_beat;
    end
  end

`ifdef EX_MEM_OF_TRAP_EN
  logic m_exc, s_exc, sticky_q;

  // Exception bits follow their beat; sticky records any exception leaving
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_exc    <= 1'b0;
      s_exc    <= 1'b0;
      sticky_q <= 1'b0;
    end else if (flush) begin
      sticky_q <= 1'b0;
    end else begin
      if (xfer && m_exc) sticky_q <= 1'b1;
      if (m_load)        m_exc <= in_exc;
      else if (m_from_s) m_exc <= s_exc;
      if (s_load)        s_exc <= in_exc;
    end
  end

  assign out_exc    = m_exc;
  assign exc_sticky = sticky_q;
`else
  assign out_exc    = 1'b0;
  assign exc_sticky = 1'b0;
`endif

  assign in_ready       = rdy_q;
  assign out_valid      = m_vld;
  assign out_aluout     = m_q.aluout;
  assign out_zero       = m_q.zero;
  assign out_uof        = m_q.uof;
  assign out_rd         = m_q.rd;
  assign out_regwrite   = m_q.regwrite;
  assign out_memread    = m_q.memread;
  assign out_memwrite   = m_q.memwrite;
  assign out_store_data = m_q.store_data;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg; trap expectations follow EX_MEM_OF_TRAP_EN.
module tb_ex_mem_reg;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [31:0] in_aluout, in_store_data, out_aluout, out_store_data;
  logic        in_zero, in_of, in_uof, in_regwrite, in_memread, in_memwrite;
  logic [3:0]  in_aluop;
  logic [4:0]  in_rd, out_rd;
  logic        out_valid, out_ready, out_zero, out_uof;
  logic        out_regwrite, out_memread, out_memwrite, out_exc, exc_sticky;

  int checks = 0;
  int errors = 0;

`ifdef EX_MEM_OF_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  ex_mem_reg #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_aluout(in_aluout), .in_zero(in_zero), .in_of(in_of), .in_uof(in_uof),
    .in_aluop(in_aluop), .in_rd(in_rd), .in_regwrite(in_regwrite),
    .in_memread(in_memread), .in_memwrite(in_memwrite),
    .in_store_data(in_store_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_aluout(out_aluout), .out_zero(out_zero), .out_uof(out_uof),
    .out_rd(out_rd), .out_regwrite(out_regwrite), .out_memread(out_memread),
    .out_memwrite(out_memwrite), .out_store_data(out_store_data),
    .out_exc(out_exc), .exc_sticky(exc_sticky)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 0;
    in_aluout = 0; in_store_data = 0; in_zero = 0; in_of = 0; in_uof = 0;
    in_aluop = 0; in_rd = 0; in_regwrite = 0; in_memread = 0; in_memwrite = 0;

    // Reset state
    step(); step();
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_aluout", out_aluout, 0);
    chk("rst_rd", {27'b0, out_rd}, 0);
    chk("rst_exc", {31'b0, out_exc}, 0);
    chk("rst_sticky", {31'b0, exc_sticky}, 0);
    rst_n = 1;
    step();

    // Full-throughput stream of 1..8
    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1; in_aluout = i; in_rd = 5'(i); in_store_data = 32'h100 + i;
      in_zero = i[0]; in_uof = i[1];
      step();
      chk("strm_valid", {31'b0, out_valid}, 1);
      chk("strm_aluout", out_aluout, i);
      chk("strm_rd", {27'b0, out_rd}, i);
      chk("strm_sdata", out_store_data, 32'h100 + i);
      chk("strm_flags", {30'b0, out_uof, out_zero}, i & 3);
      chk("strm_in_ready", {31'b0, in_ready}, 1);
    end
    in_valid = 0;
    step();
    chk("strm_drain", {31'b0, out_valid}, 0);

    // Backpressure: A then B held, in_ready drops after B
    out_ready = 0; in_valid = 1; in_aluout = 32'hA;
    step();
    chk("bp_a_valid", {31'b0, out_valid}, 1);
    chk("bp_a_ready", {31'b0, in_ready}, 1);
    in_aluout = 32'hB;
    step();
    chk("bp_b_ready", {31'b0, in_ready}, 0);
    chk("bp_b_out", out_aluout, 32'hA);
    in_valid = 0; in_aluout = 32'hEE;
    step();
    chk("bp_hold", out_aluout, 32'hA);
    chk("bp_hold_ready", {31'b0, in_ready}, 0);
    out_ready = 1;
    step();
    chk("bp_rel_b", out_aluout, 32'hB);
    chk("bp_rel_valid", {31'b0, out_valid}, 1);
    chk("bp_rel_ready", {31'b0, in_ready}, 1);
    step();
    chk("bp_empty", {31'b0, out_valid}, 0);

    // Flush with two held beats plus an offered 0xC
    out_ready = 0; in_valid = 1; in_aluout = 32'h10;
    step();
    in_aluout = 32'h11;
    step();
    chk("fl_full", {31'b0, in_ready}, 0);
    flush = 1; in_aluout = 32'hC;
    step();
    chk("fl_valid", {31'b0, out_valid}, 0);
    chk("fl_ready", {31'b0, in_ready}, 1);
    flush = 0; in_valid = 0; out_ready = 1;
    step();
    chk("fl_no_c", {31'b0, out_valid}, 0);
    // Flush with in_ready high: accepted beat must be dropped
    flush = 1; in_valid = 1; in_aluout = 32'hD;
    step();
    flush = 0; in_valid = 0;
    chk("fl_drop_d", {31'b0, out_valid}, 0);
    step();
    chk("fl_drop_d2", {31'b0, out_valid}, 0);

    // Overflow trap on add
    out_ready = 0; in_valid = 1; in_aluout = 32'h7F; in_aluop = 4'd5;
    in_of = 1; in_regwrite = 1; in_memwrite = 1;
    step();
    in_valid = 0;
    chk("tr_valid", {31'b0, out_valid}, 1);
    chk("tr_exc", {31'b0, out_exc}, {31'b0, TRAP});
    chk("tr_regwrite", {31'b0, out_regwrite}, {31'b0, !TRAP});
    chk("tr_memwrite", {31'b0, out_memwrite}, {31'b0, !TRAP});
    chk("tr_sticky_pre", {31'b0, exc_sticky}, 0);
    out_ready = 1;
    step();
    chk("tr_sticky", {31'b0, exc_sticky}, {31'b0, TRAP});
    chk("tr_gone", {31'b0, out_valid}, 0);
    flush = 1;
    step();
    flush = 0;
    chk("tr_flush_sticky", {31'b0, exc_sticky}, 0);
    // of with a non add/sub opcode never traps
    in_valid = 1; in_aluop = 4'd7; out_ready = 0;
    step();
    in_valid = 0;
    chk("tr_op7_exc", {31'b0, out_exc}, 0);
    chk("tr_op7_rw", {31'b0, out_regwrite}, 1);
    out_ready = 1;
    step();
    chk("tr_op7_sticky", {31'b0, exc_sticky}, 0);
    in_of = 0; in_aluop = 0; in_regwrite = 0; in_memwrite = 0;

    // Reset while both entries full and stalled
    out_ready = 0; in_valid = 1; in_aluout = 32'h21;
    step();
    in_aluout = 32'h22;
    step();
    chk("rm_full", {31'b0, in_ready}, 0);
    rst_n = 0; in_valid = 0;
    step();
    chk("rm_valid", {31'b0, out_valid}, 0);
    chk("rm_aluout", out_aluout, 0);
    chk("rm_ready", {31'b0, in_ready}, 1);
    rst_n = 1; out_ready = 1;
    step();
    chk("rm_no_s", {31'b0, out_valid}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

Pipeline register between the execute-stage ALU and the memory stage. Captures the ALU result, its zero/overflow flags and the instruction's control bits, and hands them to the memory stage over a valid/ready handshake. A two-entry skid buffer gives full throughput with a registered `in_ready`. Supports synchronous flush and an optional signed-overflow trap.

## Interface
- `DATA_WIDTH`, 32, width of ALU result and store data
- `REG_ADDR_WIDTH`, 5, width of destination register index
- `clk` in 1 — single clock, rising edge
- `rst_n` in 1 — synchronous, active-low reset
- `flush` in 1 — discard all held entries and the beat offered this cycle
- `in_valid` in 1 — upstream beat valid
- `in_ready` out 1 — stage can accept a beat; driven from a register
- `in_aluout` in DATA_WIDTH — ALU result
- `in_zero` / `in_of` / `in_uof` in 1 each — ALU zero, signed-overflow and unsigned-overflow flags
- `in_aluop` in 4 — ALU opcode of the instruction; 5 = add, 6 = sub
- `in_rd` in REG_ADDR_WIDTH — destination register
- `in_regwrite` / `in_memread` / `in_memwrite` in 1 each — control bits
- `in_store_data` in DATA_WIDTH — store operand
- `out_valid` out 1 — downstream beat valid
- `out_ready` in 1 — memory stage accepts
- `out_aluout`, `out_zero`, `out_uof`, `out_rd`, `out_regwrite`, `out_memread`, `out_memwrite`, `out_store_data` out — registered copies of the `in_*` fields
- `out_exc` out 1 — the current output beat carries an overflow exception
- `exc_sticky` out 1 — an exception has left this stage since the last flush or reset

## Operation
- Storage: main entry M (drives the `out_*` ports) plus skid entry S. Each entry has a valid bit.
- `in_ready` = !S.valid, registered.
- Accept occurs when `in_valid && in_ready`. Transfer occurs when `out_valid && out_ready`.
- Update rules, evaluated per cycle (M.valid before the edge):
  - M empty, accept: beat → M.
  - M full, transfer, no accept: S → M if S is valid, else M empties.
  - M full, transfer and accept: S is empty here (accept requires `in_ready`), so the new beat → M.
  - M full, no transfer, accept: beat → S.
- `out_valid` = M.valid.
- `out_*` data holds stable while `out_valid && !out_ready`.
- Data registers load only on accept or S→M move. Otherwise they retain their value.
- Flush:
  - Next edge: M.valid = S.valid = 0, and `in_ready` = 1.
  - A beat accepted in the flush cycle is dropped.
  - Flush also clears `exc_sticky`.
  - Flush has priority over every other event.
- Reset (rst_n low at an edge):
  - All valid bits, data registers, `out_exc` and `exc_sticky` go to 0.
  - `in_ready` goes to 1.
  - Reset mid-transfer loses held beats. No partial state survives.
- `exc_sticky` sets on a transfer with `out_exc` = 1. It stays set until flush or reset.
- No arithmetic is performed. Field widths pass through unchanged.

## Timing
- Latency: a beat accepted at edge N appears on `out_*` after edge N (one cycle) when M was empty or transferring.
- Throughput: one beat per cycle with `out_ready` held high.
- Backpressure: `in_ready` falls one cycle after the first stalled accept, once S fills. At most two beats are held.
- `in_ready` rises the cycle after S drains into M.
- `in_ready` never depends combinationally on `out_ready`.
- Reset values: `out_valid`=0, `in_ready`=1, all `out_*` data=0, `out_exc`=0, `exc_sticky`=0.

## Configuration
- Macro `EX_MEM_OF_TRAP_EN`.
- Defined:
  - A beat with `in_of`=1 and `in_aluop` ∈ {5,6} is stored with exc=1, and its regwrite/memread/memwrite are forced to 0.
  - `out_exc` reflects the stored exc bit of M.
- Undefined:
  - `in_of` is ignored and control bits pass unmodified.
  - `out_exc` and `exc_sticky` are tied to 0, and the exc bit storage is removed.

## Test plan
- Reset, then stream 8 beats (`in_aluout` = 1..8) with `out_ready`=1 → `out_valid` from cycle 1, one beat per cycle, values 1..8 in order, `in_ready` constant 1.
- Stream with `out_ready`=0 → accept 0xA then 0xB. `in_ready` drops after the 2nd beat. On release, 0xA then 0xB transfer in consecutive cycles, then `in_ready` returns to 1.
- Two beats held, assert `flush` together with `in_valid` (0xC) → next cycle `out_valid`=0 and `in_ready`=1, and 0xC never appears.
- With `EX_MEM_OF_TRAP_EN`: aluop=5, `in_of`=1, regwrite=1 → `out_exc`=1 and `out_regwrite`=0. After transfer `exc_sticky`=1. Flush clears it.
- Same stimulus without the macro → `out_exc`=0, `out_regwrite`=1, `exc_sticky`=0.
- `rst_n` low while S and M are full and `out_ready`=0 → next edge: `out_valid`=0, `out_aluout`=0, `in_ready`=1.
